// File: rtl/ram_fifo_pkg.sv
// Shared constants and the RAM request bundle for the single-port-RAM FIFO controller.
package ram_fifo_pkg;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 2 ** AW;

   typedef struct packed {
      logic          wr;
      logic          rd;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } ram_req_t;

endpackage

// File: rtl/ram_fifo_ptr.sv
// Wrapping AW-bit RAM pointer with increment enable and synchronous reset.
module ram_fifo_ptr #(
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   output logic [AW-1:0] ptr
);

   // Natural binary wrap (DEPTH-1 -> 0) because the depth is a power of two.
   always_ff @(posedge clk) begin
      if (rst)
         ptr <= '0;
      else if (inc)
         ptr <= ptr + 1'b1;
   end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a single-port registered-read RAM, with an output holding register.
// Optional feature: define RAM_FIFO_BYPASS_EN to let a push into an empty FIFO skip the RAM.
module ram_fifo_ctrl #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          ram_wr,
   output logic          ram_rd,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   import ram_fifo_pkg::*;

   // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
   // depends on ready, and ready may depend on valid of the other stream only via rd_go.

   localparam logic [AW:0] FULL_CNT = (AW+1)'(2 ** AW);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   ram_count;
   logic          rd_pend;
   logic          rd_go;
   logic          wr_go;
   logic          bypass_go;
   logic          push_go;
   ram_req_t      req;

   assign full  = (ram_count == FULL_CNT);
   assign count = ram_count + (AW+1)'(rd_pend) + (AW+1)'(out_valid);
   assign empty = (count == '0);

   // Reads win the RAM port so the holding register is refilled as soon as it frees up.
   assign rd_go    = !rst && (ram_count != '0) && !rd_pend && (!out_valid || out_ready);
   assign in_ready = !rst && !full && !rd_go;
   assign push_go  = in_valid && in_ready;

`ifdef RAM_FIFO_BYPASS_EN
   assign bypass_go = push_go && (ram_count == '0) && !rd_pend && (!out_valid || out_ready);
`else
   assign bypass_go = 1'b0;
`endif

   assign wr_go = push_go && !bypass_go;

   always_comb begin
      req = '0;
      if (rd_go) begin
         req.rd   = 1'b1;
         req.addr = rd_ptr;
      end else if (wr_go) begin
         req.wr    = 1'b1;
         req.addr  = wr_ptr;
         req.wdata = in_data;
      end
   end

   assign ram_wr    = req.wr;
   assign ram_rd    = req.rd;
   assign ram_addr  = req.addr;
   assign ram_wdata = req.wdata;

   ram_fifo_ptr #(.AW(AW)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .inc (wr_go),
      .ptr (wr_ptr)
   );

   ram_fifo_ptr #(.AW(AW)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .inc (rd_go),
      .ptr (rd_ptr)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ram_count <= '0;
         rd_pend   <= 1'b0;
      end else begin
         if (wr_go && !rd_go)
            ram_count <= ram_count + 1'b1;
         else if (rd_go && !wr_go)
            ram_count <= ram_count - 1'b1;
         rd_pend <= rd_go;
      end
   end

   // Any ram_rdata still in flight when reset hits is dropped because rd_pend clears.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (rd_pend) begin
         out_valid <= 1'b1;
         out_data  <= ram_rdata;
      end else if (bypass_go) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a behavioural 32x32 registered-read RAM.
module tb_ram_fifo_ctrl;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          ram_wr;
   logic          ram_rd;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata = '0;
   logic [AW:0]   count;
   logic          full;
   logic          empty;

   logic [DW-1:0] mem [0:31];
   logic [DW-1:0] exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;
   int n_popped = 0;
   int inv_err  = 0;

   always #5 clk = ~clk;

   ram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .ram_wr    (ram_wr),
      .ram_rd    (ram_rd),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always @(posedge clk) begin
      if (ram_wr) mem[ram_addr] <= ram_wdata;
      if (ram_rd) ram_rdata <= mem[ram_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive(input logic r, input logic iv, input logic [DW-1:0] d, input logic ordy);
      rst       = r;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      #1;
   endtask

   // Scoreboard update on the stable pre-edge values, then advance one cycle.
   task automatic tick();
      logic [DW-1:0] exp_v;
      if (rst) begin
         exp_q.delete();
      end else begin
         if (ram_wr && ram_rd) inv_err++;
         if (!ram_wr && !ram_rd && (ram_addr != '0 || ram_wdata != '0)) inv_err++;
         if (in_valid && in_ready) exp_q.push_back(in_data);
         if (out_valid && out_ready) begin
            n_popped++;
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL sb_underflow: got %h expected nothing", out_data);
            end else begin
               exp_v = exp_q.pop_front();
               if (out_data === exp_v) n_pass++;
               else $display("FAIL sb_data: got %h expected %h", out_data, exp_v);
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic          rst;
      logic          iv;
      logic [DW-1:0] d;
      logic          ordy;
      logic          e_ir;
      logic          e_wr;
      logic          e_rd;
      logic [AW-1:0] e_addr;
      logic          e_ov;
      logic [DW-1:0] e_od;
      logic [AW:0]   e_cnt;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int accepted;
      int wr_seen;
      int addr_bad;
      int pushed;
      int last_wr;
      logic wrap_seen;
      logic iv;

      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      @(negedge clk);
      drive(1, 0, 0, 0); tick();
      drive(1, 0, 0, 0); tick();

`ifndef RAM_FIFO_BYPASS_EN
      // rst iv data ordy | in_ready wr rd addr out_valid out_data count
      vecs[0] = '{1'b1, 1'b1, 32'hAAAA5555, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0,        6'd0};
      vecs[1] = '{1'b0, 1'b1, 32'h11111111, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0,        6'd0};
      vecs[2] = '{1'b0, 1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 32'h0,        6'd1};
      vecs[3] = '{1'b0, 1'b1, 32'h22222222, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 1'b0, 32'h0,        6'd1};
      vecs[4] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 32'h11111111, 6'd2};
      vecs[5] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 32'h11111111, 6'd2};
      vecs[6] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'h11111111, 6'd1};
      vecs[7] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 32'h22222222, 6'd1};
      vecs[8] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 32'h22222222, 6'd0};
      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].rst, vecs[i].iv, vecs[i].d, vecs[i].ordy);
         check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
         check($sformatf("v%0d_ram_wr", i), 32'(ram_wr), 32'(vecs[i].e_wr));
         check($sformatf("v%0d_ram_rd", i), 32'(ram_rd), 32'(vecs[i].e_rd));
         check($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].e_addr));
         check($sformatf("v%0d_ram_wdata", i), ram_wdata, vecs[i].e_wr ? vecs[i].d : 32'h0);
         check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
         check($sformatf("v%0d_out_data", i), out_data, vecs[i].e_od);
         check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
         check($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].e_cnt == 0));
         check($sformatf("v%0d_full", i), 32'(full), 32'h0);
         tick();
      end
`endif

      // Fill with the consumer stalled.
      drive(1, 0, 0, 0); tick();
      accepted = 0; wr_seen = 0; addr_bad = 0;
      for (int c = 0; c < 80 && accepted < 33; c++) begin
         drive(0, 1, 32'(accepted), 0);
         if (ram_wr) begin
            if (ram_addr != 5'(wr_seen)) addr_bad++;
            wr_seen++;
         end
         if (in_valid && in_ready) accepted++;
         tick();
      end
      check("fill_accepted", 32'(accepted), 32'd33);
      check("fill_wr_addr_seq", 32'(addr_bad), 32'd0);
`ifdef RAM_FIFO_BYPASS_EN
      check("fill_wr_count", 32'(wr_seen), 32'd32);
`else
      check("fill_wr_count", 32'(wr_seen), 32'd33);
`endif
      drive(0, 1, 32'd33, 0);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_flag", 32'(full), 32'd1);
      check("full_count", 32'(count), 32'd33);
      check("full_empty", 32'(empty), 32'd0);
      tick(); tick(); tick();
      drive(0, 1, 32'd33, 0);
      check("full_stall_held", 32'(in_ready), 32'd0);
      check("full_no_write", 32'(ram_wr), 32'd0);
      tick();
      drive(0, 0, 0, 1); tick();
      drive(0, 0, 0, 0);
      check("pop_frees_full", 32'(full), 32'd0);
      check("pop_count", 32'(count), 32'd32);
      tick();
      for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
         drive(0, 0, 0, 1'($urandom_range(0, 1)));
         tick();
      end
      check("drain_done", 32'(exp_q.size()), 32'd0);
      drive(0, 0, 0, 0);
      check("drain_count", 32'(count), 32'd0);
      check("drain_empty", 32'(empty), 32'd1);
      tick();

      // Wrap-around with random interleaving of pushes and pops.
      drive(1, 0, 0, 0); tick();
      n_popped = 0; pushed = 0; last_wr = -1; wrap_seen = 1'b0;
      for (int c = 0; c < 2000 && n_popped < 40; c++) begin
         iv = (pushed < 40) && ($urandom_range(0, 3) != 0);
         drive(0, iv, 32'(pushed), 1'($urandom_range(0, 1)));
         if (ram_wr) begin
            if (last_wr == 31 && ram_addr == 5'd0) wrap_seen = 1'b1;
            last_wr = int'(ram_addr);
         end
         if (in_valid && in_ready) pushed++;
         tick();
      end
      check("wrap_popped", 32'(n_popped), 32'd40);
`ifndef RAM_FIFO_BYPASS_EN
      check("wrap_addr_seen", 32'(wrap_seen), 32'd1);
`endif
      drive(0, 0, 0, 0);
      check("wrap_count", 32'(count), 32'd0);
      check("wrap_empty", 32'(empty), 32'd1);
      tick();

      // Reset while a read is in flight.
      drive(1, 0, 0, 0); tick();
      drive(0, 1, 32'h5A5A0001, 0);
`ifndef RAM_FIFO_BYPASS_EN
      check("rstmid_push_wr", 32'(ram_wr), 32'd1);
`endif
      tick();
      drive(0, 0, 0, 0);
`ifndef RAM_FIFO_BYPASS_EN
      check("rstmid_rd_issue", 32'(ram_rd), 32'd1);
`endif
      tick();
      drive(1, 0, 0, 0); tick();
      drive(0, 0, 0, 0);
      check("rstmid_out_valid", 32'(out_valid), 32'd0);
      check("rstmid_count", 32'(count), 32'd0);
      tick();
      drive(0, 0, 0, 0);
      check("rstmid_out_valid_late", 32'(out_valid), 32'd0);
      tick();
      drive(0, 1, 32'h5A5A0002, 0);
`ifndef RAM_FIFO_BYPASS_EN
      check("rstmid_repush_wr", 32'(ram_wr), 32'd1);
      check("rstmid_repush_addr", 32'(ram_addr), 32'd0);
`else
      check("rstmid_repush_wr", 32'(ram_wr), 32'd0);
`endif
      tick();
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
         drive(0, 0, 0, 1);
         tick();
      end
      check("rstmid_drain", 32'(exp_q.size()), 32'd0);

`ifdef RAM_FIFO_BYPASS_EN
      drive(1, 0, 0, 0); tick();
      drive(0, 1, 32'hDEADBEEF, 0);
      check("byp_in_ready", 32'(in_ready), 32'd1);
      check("byp_no_wr", 32'(ram_wr), 32'd0);
      tick();
      drive(0, 0, 0, 1);
      check("byp_out_valid", 32'(out_valid), 32'd1);
      check("byp_out_data", out_data, 32'hDEADBEEF);
      tick();
`endif

      check("port_invariants", 32'(inv_err), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
